linebuf_stream_reader: RTL and testbench
========================================

# linebuf_stream_reader

Frame-buffer read engine that turns a stored frame back into an AXI4-Stream video stream. On a start pulse it issues sequential reads to a synchronous-read pixel memory (1-cycle read latency) and emits H_ACTIVE×V_ACTIVE beats with tuser marking start-of-frame and tlast marking end-of-line. It is the reader-side counterpart to the stream-to-memory write path in the processing core, and it feeds downstream stages through a 2-entry output buffer that sustains full throughput under backpressure.

## Interface
- TDATA_WIDTH, 24: pixel width; memory data width.
- ADDR_WIDTH, 17: memory address width.
- H_ACTIVE, 320: pixels per line (≥1).
- V_ACTIVE, 240: lines per frame (≥1); H_ACTIVE*V_ACTIVE ≤ 2^ADDR_WIDTH.
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_start  in  1  one-cycle frame request; honoured only in IDLE.
- i_base_addr  in  ADDR_WIDTH  frame base address, latched on the accepted i_start.
- o_busy  out  1  high from the accepted start until the done pulse, inclusive.
- o_done  out  1  one-cycle pulse after the final beat transfers.
- o_rd_en  out  1  memory read strobe.
- o_rd_addr  out  ADDR_WIDTH  memory read address.
- i_rd_data  in  TDATA_WIDTH  read data, valid exactly one cycle after o_rd_en.
- o_tvalid  out  1  stream valid.
- i_tready  in  1  stream ready.
- o_tdata  out  TDATA_WIDTH  pixel.
- o_tuser  out  1  SOF: high on beat (x=0, y=0) only.
- o_tlast  out  1  EOL: high on beat x=H_ACTIVE-1 of every line.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on i_start, with rd_addr←i_base_addr, issue count←0, x/y←0.
  - RUN→DONE when the last beat transfers (o_tvalid&&i_tready with x=H_ACTIVE-1, y=V_ACTIVE-1).
  - DONE→IDLE unconditionally after one cycle; o_done=1 only in DONE.
- i_start in RUN or DONE is ignored. Nothing is queued.
- Read issue:
  - o_rd_en=1 in RUN when issued<H_ACTIVE*V_ACTIVE and (occ+inflight−pop)<2. occ is the number of buffer entries (0..2), inflight is the number of reads issued in the previous cycle (0/1), and pop=o_tvalid&&i_tready.
  - Each issue increments o_rd_addr, with wrap modulo 2^ADDR_WIDTH.
- Returned data is written into the 2-entry FIFO buffer in the cycle after issue. The head drives o_tdata, and o_tvalid=(occ≠0).
- x/y output counters advance on each transfer. x wraps at H_ACTIVE−1 to 0 and increments y. o_tuser and o_tlast are registered alongside the data, decoded from issue-side coordinates.
- AXI hold: while o_tvalid&&!i_tready, o_tdata/o_tuser/o_tlast stay stable and no entry is lost.
- Simultaneous push and pop with occ=2 cannot occur, because the credit rule prevents it. Push and pop with occ=1 keep occ=1.
- Reset mid-frame:
  - Return to IDLE.
  - occ=0 and inflight is discarded; i_rd_data arriving the cycle after reset is ignored.
  - No o_done.
- Outputs after reset: o_busy=0, o_done=0, o_rd_en=0, o_rd_addr=0, o_tvalid=0, o_tdata=0, o_tuser=0, o_tlast=0.

## Timing
- i_start high in cycle 0 → o_rd_en=1 with o_rd_addr=base in cycle 1.
- i_rd_data is valid in cycle 2, and o_tvalid=1 with the pixel at base in cycle 3. Start-to-first-beat latency is 3 cycles.
- With i_tready held high, one beat is issued and transferred per cycle. A frame takes H_ACTIVE*V_ACTIVE+3 cycles from start to the last transfer, and o_done follows 1 cycle later.
- After i_tready has been low for any duration, the first ready cycle transfers immediately. No bubble is inserted when occ=2.
- o_busy falls in the cycle after o_done.
- A new i_start is accepted at the earliest in the first IDLE cycle after DONE.

## Test plan
- Config H_ACTIVE=4, V_ACTIVE=2, base=0x10, memory[a]=a, i_tready=1:
  - Beats 0x10..0x17 arrive on consecutive cycles 3..10.
  - tuser=1 only on 0x10; tlast=1 on 0x13 and 0x17.
  - o_done pulses in cycle 11.
- Same config, i_tready toggling 1/0 every cycle, plus random stalls of 1–5 cycles:
  - Order is 0x10..0x17 with no drop or duplication.
  - Outputs are stable during every stall.
  - occ never exceeds 2.
- Base=2^ADDR_WIDTH−3:
  - Read addresses wrap as …FFFD, FFFE, FFFF, 0000.
  - Beats follow the same sequence.
- i_start pulsed again in cycle 5 of a frame:
  - It is ignored and the frame completes normally.
  - A start in the first IDLE cycle after DONE begins a new frame with o_rd_en one cycle later.
- i_rst asserted in cycle 6 with i_tready=0:
  - Next cycle all outputs are at reset values.
  - The stale i_rd_data is ignored.
  - No o_done.
  - A subsequent start yields the correct full frame from base.
- Config H_ACTIVE=1, V_ACTIVE=1: one beat with tuser=1 and tlast=1 in cycle 3; o_done in cycle 4.

Source files
------------

// File: rtl/linebuf_stream_reader.sv
// linebuf_stream_reader: replays a stored frame from 1-cycle-latency memory as an AXI4-Stream
// video stream. A 2-entry buffer, with credit-based read issue, keeps full throughput under backpressure.
module linebuf_stream_reader #(
    parameter int TDATA_WIDTH = 24,
    parameter int ADDR_WIDTH  = 17,
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [ADDR_WIDTH-1:0]  i_base_addr,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_rd_en,
    output logic [ADDR_WIDTH-1:0]  o_rd_addr,
    input  logic [TDATA_WIDTH-1:0] i_rd_data,
    output logic                   o_tvalid,
    input  logic                   i_tready,
    output logic [TDATA_WIDTH-1:0] o_tdata,
    output logic                   o_tuser,
    output logic                   o_tlast
);
    localparam int N  = H_ACTIVE * V_ACTIVE;
    localparam int CW = $clog2(N + 1);
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [CW-1:0] issued_q, issued_d;
    logic [XW-1:0] ix_q, ix_d, ox_q, ox_d;
    logic [YW-1:0] iy_q, iy_d, oy_q, oy_d;
    logic infl_q, infl_d, infl_user_q, infl_user_d, infl_last_q, infl_last_d;
    logic [1:0] occ_q, occ_d;
    logic wp_q, wp_d, rp_q, rp_d;
    logic [1:0][TDATA_WIDTH-1:0] buf_data_q;
    logic [1:0] buf_user_q, buf_last_q;
    logic start_acc, pop, credit, more, ix_last, ox_last, last_beat;

    // A read may issue only if the entry it lands in is guaranteed free next cycle.
    always_comb begin
        o_tvalid  = occ_q != 2'd0;
        pop       = o_tvalid && i_tready;
        credit    = ({1'b0, occ_q} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop});
        more      = issued_q != CW'(N);
        ix_last   = ix_q == XW'(H_ACTIVE - 1);
        ox_last   = ox_q == XW'(H_ACTIVE - 1);
        last_beat = pop && ox_last && oy_q == YW'(V_ACTIVE - 1);
        start_acc = state_q == IDLE && i_start;
        o_tdata   = o_tvalid ? buf_data_q[rp_q] : '0;
        o_tuser   = o_tvalid && buf_user_q[rp_q];
        o_tlast   = o_tvalid && buf_last_q[rp_q];
        o_rd_addr = rd_addr_q;
    end

    always_ff @(posedge i_clk) begin
        state_q <= i_rst ? IDLE : state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (i_start ? RUN : IDLE) :
                  state_q == RUN  ? (last_beat ? DONE : RUN) : IDLE;
    end

    always_comb begin
        o_busy  = state_q != IDLE;
        o_done  = state_q == DONE;
        o_rd_en = state_q == RUN && more && credit;
    end

    always_comb begin
        rd_addr_d   = start_acc ? i_base_addr : o_rd_en ? rd_addr_q + ADDR_WIDTH'(1) : rd_addr_q;
        issued_d    = start_acc ? '0 : issued_q + CW'(o_rd_en);
        ix_d        = start_acc ? '0 : !o_rd_en ? ix_q : ix_last ? '0 : ix_q + XW'(1);
        iy_d        = start_acc ? '0 : (o_rd_en && ix_last) ? iy_q + YW'(1) : iy_q;
        ox_d        = start_acc ? '0 : !pop ? ox_q : ox_last ? '0 : ox_q + XW'(1);
        oy_d        = start_acc ? '0 : (pop && ox_last) ? oy_q + YW'(1) : oy_q;
        infl_d      = o_rd_en;
        infl_user_d = ix_q == '0 && iy_q == '0;
        infl_last_d = ix_last;
        occ_d       = occ_q + {1'b0, infl_q} - {1'b0, pop};
        wp_d        = wp_q ^ infl_q;
        rp_d        = rp_q ^ pop;
    end

    // Clearing infl_q on reset drops the read data that returns just after it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_addr_q   <= '0;
            issued_q    <= '0;
            ix_q        <= '0;
            iy_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            infl_q      <= 1'b0;
            infl_user_q <= 1'b0;
            infl_last_q <= 1'b0;
            occ_q       <= '0;
            wp_q        <= 1'b0;
            rp_q        <= 1'b0;
            buf_data_q  <= '0;
            buf_user_q  <= '0;
            buf_last_q  <= '0;
        end else begin
            rd_addr_q   <= rd_addr_d;
            issued_q    <= issued_d;
            ix_q        <= ix_d;
            iy_q        <= iy_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            infl_q      <= infl_d;
            infl_user_q <= infl_user_d;
            infl_last_q <= infl_last_d;
            occ_q       <= occ_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            if (infl_q) begin
                buf_data_q[wp_q] <= i_rd_data;
                buf_user_q[wp_q] <= infl_user_q;
                buf_last_q[wp_q] <= infl_last_q;
            end
        end
    end
endmodule

// File: tb/tb_linebuf_stream_reader.sv
// tb_linebuf_stream_reader: scoreboard bench for a 4x2 reader plus a 1x1 reader,
// each fed by a memory model returning its own address as data.
module tb_linebuf_stream_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, busy, done, rd_en, tvalid, tready, tuser, tlast;
    logic [16:0] base, rd_addr;
    logic [23:0] rd_data, tdata;
    logic u_start, u_busy, u_done, u_rd_en, u_tvalid, u_tready, u_tuser, u_tlast;
    logic [16:0] u_base, u_rd_addr;
    logic [23:0] u_rd_data, u_tdata;

    linebuf_stream_reader #(.TDATA_WIDTH(24), .ADDR_WIDTH(17), .H_ACTIVE(4), .V_ACTIVE(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base), .o_busy(busy),
        .o_done(done), .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_tvalid(tvalid), .i_tready(tready), .o_tdata(tdata), .o_tuser(tuser), .o_tlast(tlast));

    linebuf_stream_reader #(.TDATA_WIDTH(24), .ADDR_WIDTH(17), .H_ACTIVE(1), .V_ACTIVE(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(u_start), .i_base_addr(u_base), .o_busy(u_busy),
        .o_done(u_done), .o_rd_en(u_rd_en), .o_rd_addr(u_rd_addr), .i_rd_data(u_rd_data),
        .o_tvalid(u_tvalid), .i_tready(u_tready), .o_tdata(u_tdata), .o_tuser(u_tuser), .o_tlast(u_tlast));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory[a] = a; anything outside the valid read slot is junk
    always @(posedge clk) rd_data <= rd_en ? {7'b0, rd_addr} : 24'hDEAD00;
    always @(posedge clk) u_rd_data <= u_rd_en ? {7'b0, u_rd_addr} : 24'hDEAD00;

    typedef struct {
        logic [23:0] d;
        logic        u;
        logic        l;
        int          c;
    } beat_t;
    beat_t sb0[$], sb1[$];

    int n_chk = 0, n_fail = 0, done_cnt = 0, mode = 0, st = 0, dc = 0, dn = 0;
    logic hold_v = 1'b0;
    logic [25:0] hold_val;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        beat_t e;
        if (rst) hold_v = 1'b0;
        else begin
            if (hold_v) begin
                chk("hold_valid", {31'b0, tvalid}, 1);
                chk("hold_payload", {6'b0, tuser, tlast, tdata}, {6'b0, hold_val});
            end
            hold_v = tvalid && !tready;
            hold_val = {tuser, tlast, tdata};
            if (done) done_cnt++;
            if (tvalid && tready) begin
                if (sb0.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_beat: got tdata %0h expected no beat", tdata);
                end else begin
                    e = sb0.pop_front();
                    chk("tdata", {8'b0, tdata}, {8'b0, e.d});
                    chk("tuser", {31'b0, tuser}, {31'b0, e.u});
                    chk("tlast", {31'b0, tlast}, {31'b0, e.l});
                    if (e.c >= 0) chk("beat_cycle", cyc, e.c);
                end
            end
            if (u_tvalid && u_tready) begin
                if (sb1.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL u_extra_beat: got tdata %0h expected no beat", u_tdata);
                end else begin
                    e = sb1.pop_front();
                    chk("u_tdata", {8'b0, u_tdata}, {8'b0, e.d});
                    chk("u_tuser", {31'b0, u_tuser}, {31'b0, e.u});
                    chk("u_tlast", {31'b0, u_tlast}, {31'b0, e.l});
                    chk("u_beat_cycle", cyc, e.c);
                end
            end
        end
    end

    // mode 0: always ready, 1: toggling with random stalls, 3: driven by the stimulus
    initial begin : rdy
        int stall;
        stall = 0;
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 0) tready = 1'b1;
            else if (mode == 1) begin
                if (stall > 0) begin
                    tready = 1'b0;
                    stall--;
                end else if ($urandom_range(0, 3) == 0) begin
                    stall = $urandom_range(0, 4);
                    tready = 1'b0;
                end else tready = !tready;
            end
        end
    end

    task automatic start_frame(input logic [16:0] b, input bit timed);
        beat_t e;
        logic [16:0] a;
        @(posedge clk);
        #1;
        start = 1'b1;
        base = b;
        st = cyc;
        for (int i = 0; i < 8; i++) begin
            a = b + 17'(i);
            e.d = {7'b0, a};
            e.u = (i == 0);
            e.l = (i % 4 == 3);
            e.c = timed ? st + 3 + i : -1;
            sb0.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        base = '0;
    endtask

    task automatic wait_done(output int c);
        c = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no o_done expected one within 200 cycles");
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_done"}, {31'b0, done}, 0);
        chk({tag, "_rd_en"}, {31'b0, rd_en}, 0);
        chk({tag, "_rd_addr"}, {15'b0, rd_addr}, 0);
        chk({tag, "_tvalid"}, {31'b0, tvalid}, 0);
        chk({tag, "_tdata"}, {8'b0, tdata}, 0);
        chk({tag, "_tuser"}, {31'b0, tuser}, 0);
        chk({tag, "_tlast"}, {31'b0, tlast}, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base = '0;
        u_start = 1'b0;
        u_base = '0;
        u_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // full-rate frame with exact beat and done timing
        start_frame(17'h10, 1);
        @(negedge clk);
        chk("t1_rd_en_c1", {31'b0, rd_en}, 1);
        chk("t1_rd_addr_c1", {15'b0, rd_addr}, 32'h10);
        chk("t1_busy", {31'b0, busy}, 1);
        wait_done(dc);
        chk("t1_done_cycle", dc, st + 11);
        @(negedge clk);
        chk("t1_busy_fall", {31'b0, busy}, 0);
        chk("t1_done_once", {31'b0, done}, 0);
        chk("t1_sb_empty", sb0.size(), 0);

        // backpressure: toggling ready with random stalls
        mode = 1;
        start_frame(17'h10, 0);
        wait_done(dc);
        mode = 0;
        @(negedge clk);
        chk("t2_sb_empty", sb0.size(), 0);

        // address wrap at the top of memory
        start_frame(17'h1FFFD, 1);
        for (int i = 0; i < 4; i++) begin
            logic [16:0] a;
            a = 17'h1FFFD + 17'(i);
            @(negedge clk);
            chk("t3_rd_en", {31'b0, rd_en}, 1);
            chk("t3_rd_addr", {15'b0, rd_addr}, {15'b0, a});
        end
        wait_done(dc);
        chk("t3_done_cycle", dc, st + 11);
        chk("t3_sb_empty", sb0.size(), 0);

        // start during a frame is ignored; back-to-back restart right after DONE
        start_frame(17'h10, 1);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        base = 17'h40;
        @(posedge clk);
        #1;
        start = 1'b0;
        base = '0;
        wait_done(dc);
        chk("t4_done_cycle", dc, st + 11);
        chk("t4_sb_empty", sb0.size(), 0);
        start_frame(17'h20, 1);
        chk("t4_restart_cycle", st, dc + 1);
        @(negedge clk);
        chk("t4_restart_rd_en", {31'b0, rd_en}, 1);
        chk("t4_restart_rd_addr", {15'b0, rd_addr}, 32'h20);
        wait_done(dc);
        chk("t4_done2_cycle", dc, st + 11);
        chk("t4_sb2_empty", sb0.size(), 0);

        // reset mid-frame while stalled
        mode = 3;
        tready = 1'b1;
        start_frame(17'h10, 0);
        repeat (5) @(posedge clk);
        #1;
        tready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_beats_before_rst", sb0.size(), 5);
        sb0.delete();
        dn = done_cnt;
        @(negedge clk);
        chk_reset_outs("t5");
        repeat (4) @(negedge clk);
        chk("t5_no_done", done_cnt, dn);
        chk("t5_idle_tvalid", {31'b0, tvalid}, 0);
        tready = 1'b1;
        mode = 0;
        start_frame(17'h10, 1);
        wait_done(dc);
        chk("t5_done_cycle", dc, st + 11);
        chk("t5_sb_empty", sb0.size(), 0);

        // single-pixel frame
        @(posedge clk);
        #1;
        u_start = 1'b1;
        u_base = 17'h5;
        st = cyc;
        sb1.push_back('{d: 24'h5, u: 1'b1, l: 1'b1, c: st + 3});
        @(posedge clk);
        #1;
        u_start = 1'b0;
        dc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (u_done) begin
                dc = cyc;
                break;
            end
        end
        chk("t6_done_cycle", dc, st + 4);
        chk("t6_sb_empty", sb1.size(), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end
endmodule
